// File: rtl/rvx_muldiv_unit.sv
// RV M-extension execute unit: fixed-latency multiplier and iterative radix-2 restoring divider.
// Holds the upstream pipeline through stall_req while an op is in flight.
module rvx_muldiv_unit #(
    parameter int XLEN          = 32,
    parameter int MUL_STAGES    = 2,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            cancel,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] c
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_INIT = CW'((MUL_STAGES >= 2) ? (MUL_STAGES - 2) : 0);
    localparam logic [CW-1:0] DIV_INIT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [XLEN-1:0] quo_d, rem_d;
    logic            done_q;
    logic [4:0]      rdo_q;
    logic [XLEN-1:0] c_q;

    // Magnitude of an operand that is only negative when treated as signed.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    // Final divide/remainder value, including divide-by-zero; fop[1]=rem, fop[0]=unsigned.
    function automatic logic [XLEN-1:0] div_fix(input logic [1:0] fop,
                                                input logic [XLEN-1:0] fa, fb, fq, fr);
        logic neg_q, neg_r;
        if (fb == '0)
            return fop[1] ? fa : '1;
        neg_q = ~fop[0] & (fa[XLEN-1] ^ fb[XLEN-1]);
        neg_r = ~fop[0] & fa[XLEN-1];
        return fop[1] ? (neg_r ? -fr : fr) : (neg_q ? -fq : fq);
    endfunction

    // Multiplier operands come straight from the ports only for single-cycle multiplies.
    logic [2:0]             mop;
    logic [XLEN-1:0]        ma, mb;
    logic signed [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod;
    logic [XLEN-1:0]        mul_res;

    always_comb begin
        mop       = (state_q == S_IDLE) ? op : op_q;
        ma        = (state_q == S_IDLE) ? a  : a_q;
        mb        = (state_q == S_IDLE) ? b  : b_q;
        mul_a_ext = {{XLEN{ma[XLEN-1] & ((mop == 3'd1) | (mop == 3'd2))}}, ma};
        mul_b_ext = {{XLEN{mb[XLEN-1] & (mop == 3'd1)}}, mb};
        prod      = mul_a_ext * mul_b_ext;
        mul_res   = (mop == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic [XLEN:0] shifted, diff;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    logic in_early;
    assign in_early = (DIV_EARLY_OUT != 0) &&
                      ((b == '0) || (~op[0] && (a == INT_MIN) && (b == '1)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            done_q  <= 1'b0;
            rdo_q   <= '0;
            c_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !cancel) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        rd_q <= rd_in;
                        if (!op[2]) begin
                            if (MUL_STAGES == 1) begin
                                c_q    <= mul_res;
                                rdo_q  <= rd_in;
                                done_q <= 1'b1;
                            end else begin
                                state_q <= S_MUL;
                                cnt_q   <= MUL_INIT;
                            end
                        end else if (in_early) begin
                            // Overflow case reuses div_fix: quotient magnitude a, remainder 0.
                            c_q    <= div_fix(op[1:0], a, b, a, '0);
                            rdo_q  <= rd_in;
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_DIV;
                            cnt_q   <= DIV_INIT;
                            quo_q   <= mag(a, ~op[0]);
                            rem_q   <= '0;
                            dvs_q   <= mag(b, ~op[0]);
                        end
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        c_q     <= mul_res;
                        rdo_q   <= rd_q;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        state_q <= S_IDLE;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        if (cnt_q == '0)
                            state_q <= S_FIX;
                        else
                            cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        c_q    <= div_fix(op_q[1:0], a_q, b_q, quo_q, rem_q);
                        rdo_q  <= rd_q;
                        done_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign stall_req = (start & ~busy) | busy;
    assign done      = done_q;
    assign rd        = rdo_q;
    assign c         = c_q;
endmodule

// File: tb/tb_rvx_muldiv_unit.sv
// Randomised and directed bench for rvx_muldiv_unit (XLEN=32, MUL_STAGES=2)
// against a plain-arithmetic reference model.
module tb_rvx_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, stall_req, done;
    logic [4:0]  rd;
    logic [31:0] c;

    int total = 0;
    int bad = 0;

    rvx_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_EARLY_OUT(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .cancel(cancel), .busy(busy), .stall_req(stall_req),
        .done(done), .rd(rd), .c(c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] fop, input logic [31:0] fa, fb);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        ua = longint'(fa);
        ub = longint'(fb);
        case (fop)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (fb == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (fb == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (fb == 0) return fa; p = sa % sb; return p[31:0]; end
            default: begin if (fb == 0) return fa; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] fop, input logic [31:0] fa, fb);
        if (fop < 3'd4) return 2;
        if (fb == 0) return 1;
        if (!fop[0] && fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Drives a request at the current time; returns 1ns after the accepting edge (cycle 1).
    task automatic issue(input logic [2:0] o, input logic [31:0] x, y, input logic [4:0] r);
        op = o; a = x; b = y; rd_in = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [31:0] ec, input logic [4:0] erd);
        int n = 1;
        bit bok = 1'b1;
        while (!done && n < 100) begin
            if (!(busy && stall_req)) bok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_c"}, 64'(c), 64'(ec));
        check({tag, "_rd"}, 64'(rd), 64'(erd));
        check({tag, "_busy"}, {63'b0, bok}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, y, input logic [4:0] r);
        @(negedge clk);
        op = o; a = x; b = y; rd_in = r; start = 1'b1;
        #1 check({tag, "_stall"}, {63'b0, stall_req}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(tag, ref_lat(o, x, y), ref_res(o, x, y), r);
    endtask

    initial begin
        int nd;
        logic [31:0] c_before;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1 check("reset_state", {58'b0, busy, done, stall_req, 1'b0, rd, c} == '0 ? 64'd0 : 64'd1, 64'd0);
        check("reset_c", 64'(c), 64'd0);
        @(negedge clk) reset_n = 1'b1;

        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        check("mulhu_ff_val", 64'(c), 64'h0000_0000_FFFF_FFFE);
        run_op("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        check("mul_ff_val", 64'(c), 64'h1);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3);
        check("div_m7_2_val", 64'(c), 64'h0000_0000_FFFF_FFFD);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4);
        check("rem_m7_2_val", 64'(c), 64'h0000_0000_FFFF_FFFF);
        run_op("divu_5_0", 3'd5, 32'd5, 32'd0, 5'd5);
        check("divu_5_0_val", 64'(c), 64'h0000_0000_FFFF_FFFF);
        run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 5'd6);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        check("div_ovf_val", 64'(c), 64'h0000_0000_8000_0000);
        run_op("rd_zero", 3'd1, 32'h1234_5678, 32'h8765_4321, 5'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = rnd_val();
            rb = rnd_val();
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, 5'($urandom_range(0, 31)));
        end

        // Cancel in cycle 10 of a divide, then issue a multiply in cycle 11.
        run_op("pre_cancel", 3'd0, 32'd3, 32'd5, 5'd8);
        c_before = c;
        @(negedge clk);
        issue(3'd5, 32'd1000, 32'd7, 5'd9);
        nd = done ? 1 : 0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_nodone", 64'(nd + (done ? 1 : 0)), 64'd0);
        check("cancel_c", 64'(c), 64'(c_before));
        issue(3'd0, 32'd6, 32'd7, 5'd10);
        wait_done("post_cancel_mul", 2, 32'd42, 5'd10);

        // Back-to-back: multiply issued in the done cycle of a divide; a start while busy is ignored.
        run_op("b2b_div", 3'd5, 32'd100, 32'd7, 5'd11);
        issue(3'd0, 32'd9, 32'd9, 5'd12);
        check("b2b_busy1", 64'(busy), 64'd1);
        op = 3'd5; a = 32'd50; b = 32'd3; rd_in = 5'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_c", 64'(c), 64'd81);
        check("b2b_rd", 64'(rd), 64'd12);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        check("ignored_start", 64'(nd), 64'd0);

        // Cancel together with start in IDLE must not accept the op.
        @(negedge clk);
        op = 3'd0; a = 32'd2; b = 32'd2; rd_in = 5'd14; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        nd = busy ? 1 : 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("cancel_idle_start", 64'(nd), 64'd0);

        // Reset in cycle 5 of a divide.
        run_op("pre_reset", 3'd0, 32'd11, 32'd13, 5'd15);
        @(negedge clk);
        issue(3'd4, 32'd12345, 32'd17, 5'd16);
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midop_reset", {26'b0, busy, done, rd, c}, 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        check("reset_no_stale_done", 64'(nd), 64'd0);
        run_op("post_reset", 3'd7, 32'd100, 32'd7, 5'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
